// File: rtl/ahb_frame_buffer.sv
// ahb_frame_buffer: AHB-Lite image buffer with wait states, control/status registers
// and a valid/ready stream port that drains LEN words from the buffer.
module ahb_frame_buffer #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int LED_W       = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic             HREADY,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [LED_W-1:0] LED
);
    typedef enum logic {B_IDLE, B_WAIT} bus_t;
    typedef enum logic {S_IDLE, S_RUN} str_t;
    localparam logic [ADDR_W:0] ONE = 1;

    logic [31:0]       mem [2**ADDR_W];
    bus_t              bus_st_q;
    str_t              str_st_q;
    logic              hready_q, dph_q, write_q, done_q, m_valid_q, m_last_q;
    logic [2:0]        size_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W+2:0] addr_q;
    logic [ADDR_W:0]   len_q, flen_q, ptr_q;
    logic [31:0]       hrdata_q, m_data_q, reg_rd_d;
    logic [3:0]        be_d;
    logic [ADDR_W-1:0] widx;
    logic              accept, commit, sel_buf, buf_acc, reg_wr, ctrl_wr, start, clr, fetch, hs, busy;
    logic              unused;

    always_comb begin
        accept   = HSEL & HREADY & HTRANS[1] & hready_q;
        commit   = dph_q & hready_q;
        sel_buf  = !addr_q[ADDR_W+2];
        widx     = addr_q[ADDR_W+1:2];
        buf_acc  = commit & sel_buf;
        reg_wr   = commit & write_q & !sel_buf;
        ctrl_wr  = reg_wr & (addr_q[3:2] == 2'd0);
        busy     = str_st_q == S_RUN;
        start    = ctrl_wr & HWDATA[0] & !busy & (len_q != '0);
        clr      = ctrl_wr & HWDATA[1];
        hs       = m_valid_q & m_ready;
        // a committing AHB buffer access owns the memory port this cycle
        fetch    = busy & (ptr_q < flen_q) & (!m_valid_q | m_ready) & !buf_acc;
        be_d     = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                   size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        reg_rd_d = addr_q[3:2] == 2'd1 ? {30'b0, done_q, busy} :
                   addr_q[3:2] == 2'd2 ? 32'(len_q) : 32'b0;
    end

    always_ff @(posedge HCLK)
        if (buf_acc && write_q)
            for (int i = 0; i < 4; i++)
                if (be_d[i]) mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus_st_q <= B_IDLE;
            hready_q <= 1'b1;
            dph_q    <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            hrdata_q <= '0;
            len_q    <= '0;
        end else begin
            if (commit) begin
                dph_q <= 1'b0;
                if (!write_q) hrdata_q <= sel_buf ? mem[widx] : reg_rd_d;
                if (reg_wr && addr_q[3:2] == 2'd2) len_q <= HWDATA[ADDR_W:0];
                if (bus_st_q == B_WAIT) bus_st_q <= B_IDLE;
            end else if (bus_st_q == B_WAIT && !hready_q) begin
                if (cnt_q == '0) hready_q <= 1'b1;
                else cnt_q <= cnt_q - 4'd1;
            end
            if (accept) begin
                dph_q   <= 1'b1;
                write_q <= HWRITE;
                size_q  <= HSIZE;
                addr_q  <= HADDR[ADDR_W+2:0];
                if (WAIT_CYCLES > 0) begin
                    bus_st_q <= B_WAIT;
                    hready_q <= 1'b0;
                    cnt_q    <= 4'(WAIT_CYCLES - 1);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            str_st_q  <= S_IDLE;
            done_q    <= 1'b0;
            flen_q    <= '0;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            if (clr) done_q <= 1'b0;
            if (start) begin
                str_st_q <= S_RUN;
                flen_q   <= len_q;
                ptr_q    <= '0;
            end
            if (fetch) begin
                m_data_q  <= mem[ptr_q[ADDR_W-1:0]];
                m_last_q  <= ptr_q == flen_q - ONE;
                m_valid_q <= 1'b1;
                ptr_q     <= ptr_q + ONE;
            end else if (hs) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            if (hs && m_last_q) begin
                str_st_q <= S_IDLE;
                done_q   <= 1'b1;
            end
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = 1'b0;
    assign HRDATA    = hrdata_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign LED       = mem[0][LED_W-1:0];
    assign unused    = ^{HADDR[31:ADDR_W+3], HTRANS[0]};
endmodule

// File: tb/tb_ahb_frame_buffer.sv
// tb_ahb_frame_buffer: randomized AHB + stream stimulus against a behavioural model
// of the buffer contents, registers and expected frame sequences.
module tb_ahb_frame_buffer;
    localparam int ADDR_W = 10, WAIT_CYCLES = 2, LED_W = 8;
    localparam logic [31:0] RB = 32'h1 << (ADDR_W + 2);

    logic             HCLK, HRESETn, HSEL, HREADY, HWRITE, HREADYOUT, HRESP, m_valid, m_ready, m_last;
    logic [31:0]      HADDR, HWDATA, HRDATA, m_data;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic [LED_W-1:0] LED;

    ahb_frame_buffer #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .LED_W(LED_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .LED(LED)
    );

    assign HREADY = HREADYOUT;
    initial HCLK = 0;
    always #5 HCLK = ~HCLK;

    int checks = 0, errors = 0;
    logic [31:0] mdl [2**ADDR_W];
    logic [31:0] exp_q[$], rx_d[$];
    bit          rx_l[$];
    int          rx_t[$];
    int          len_m = 0, mode = 0, pc = 0, vcount = 0, cyc = 0;
    bit          done_m = 0, stalled = 0;
    logic [31:0] prev_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(posedge HCLK) cyc++;

    // downstream consumer: drives m_ready and records every handshake
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (stalled && m_valid) check("stall_hold", m_data, prev_d);
            m_ready = mode == 0 ? 1'b1 : mode == 1 ? (pc % 3 == 0) : 1'($urandom_range(0, 1));
            pc++;
            if (m_valid) vcount++;
            if (m_valid && m_ready) begin
                rx_d.push_back(m_data);
                rx_l.push_back(m_last);
                rx_t.push_back(cyc);
            end
            stalled = m_valid && !m_ready;
            prev_d  = m_data;
        end else stalled = 0;
    end

    task automatic ahb(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd);
        int n = 0;
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = wd;
        while (!HREADYOUT && n < 50) begin
            n++;
            @(posedge HCLK); #1;
        end
        check("wait_states", n, WAIT_CYCLES);
        @(posedge HCLK); #1;
        rd = HRDATA;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int nb, base;
        ahb(1, a, sz, d, r);
        if (!a[ADDR_W+2]) begin
            nb   = sz == 0 ? 1 : sz == 1 ? 2 : 4;
            base = int'(a[1:0]) / nb * nb;
            for (int k = base; k < base + nb; k++) mdl[a[ADDR_W+1:2]][8*k +: 8] = d[8*k +: 8];
        end else if (a[3:2] == 2'd2) len_m = int'(d[ADDR_W:0]);
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        ahb(0, a, 3'd2, 32'h0, r);
        check(tag, r, exp);
    endtask

    task automatic start_frame(input int n, input int m);
        mode = m;
        bus_wr(RB + 8, 3'd2, n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mdl[i]);
        rx_d.delete(); rx_l.delete(); rx_t.delete();
        bus_wr(RB, 3'd2, 32'h1);
    endtask

    task automatic finish_frame();
        int n = exp_q.size(), t = 0;
        while (rx_d.size() < n && t < 3000) begin
            @(posedge HCLK);
            t++;
        end
        repeat (2) @(posedge HCLK);
        #1;
        check("frame_count", rx_d.size(), n);
        for (int i = 0; i < n && i < rx_d.size(); i++) begin
            check("frame_data", rx_d[i], exp_q[i]);
            check("frame_last", 32'(rx_l[i]), 32'(i == n - 1));
        end
        check("valid_drop", 32'(m_valid), 0);
        done_m = 1;
        bus_rd("status_done", RB + 4, {30'b0, done_m, 1'b0});
        bus_wr(RB, 3'd2, 32'h2);
        done_m = 0;
        bus_rd("status_clr", RB + 4, {30'b0, done_m, 1'b0});
    endtask

    initial begin
        logic [31:0] d;
        int t;
        HRESETn = 0; HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0; m_ready = 0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", 32'(HREADYOUT), 1);
        check("rst_hrdata", HRDATA, 0);
        check("rst_hresp", 32'(HRESP), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", m_data, 0);
        HRESETn = 1;
        bus_rd("rst_status", RB + 4, 0);
        bus_rd("rst_len", RB + 8, 0);

        bus_wr(32'h40, 3'd2, 32'hDEADBEEF);
        bus_rd("word_rd", 32'h40, 32'hDEADBEEF);
        bus_wr(32'h0, 3'd2, 32'h11223344);
        bus_wr(32'h3, 3'd0, 32'hAA000000);
        bus_rd("byte_wr", 32'h0, 32'hAA223344);
        bus_wr(32'h0, 3'd1, 32'h00005566);
        bus_rd("half_wr", 32'h0, 32'hAA225566);
        check("led", 32'(LED), 32'h66);
        bus_wr(RB + 12, 3'd2, 32'hFFFFFFFF);
        bus_rd("reg3_zero", RB + 12, 0);
        bus_rd("ctrl_zero", RB, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a  = 32'h80 + 4 * $urandom_range(0, 31);
            sz = 3'($urandom_range(0, 2));
            bus_wr(a, 3'd2, $urandom);
            a[1:0] = sz == 0 ? 2'($urandom_range(0, 3)) : sz == 1 ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            bus_wr(a, sz, $urandom);
            bus_rd("rand_partial", {a[31:2], 2'b00}, mdl[a[ADDR_W+1:2]]);
        end

        for (int i = 0; i < 4; i++) bus_wr(4 * i, 3'd2, i + 1);
        check("led_fill", 32'(LED), 32'h01);
        start_frame(4, 0);
        finish_frame();
        if (rx_t.size() == 4) check("back_to_back", rx_t[3] - rx_t[0], 3);
        else check("back_to_back_count", rx_t.size(), 4);

        for (int i = 0; i < 16; i++) bus_wr(4 * i, 3'd2, $urandom);
        start_frame(10, 1);
        bus_wr(RB + 8, 3'd2, 3);
        bus_wr(RB, 3'd2, 32'h1);
        finish_frame();
        bus_rd("len_rd", RB + 8, len_m);

        vcount = 0;
        bus_wr(RB + 8, 3'd2, 0);
        bus_wr(RB, 3'd2, 32'h1);
        repeat (10) @(posedge HCLK);
        check("len0_no_valid", vcount, 0);
        bus_rd("len0_status", RB + 4, 0);

        for (int i = 0; i < 12; i++) bus_wr(4 * i, 3'd2, $urandom);
        start_frame(12, 2);
        for (int i = 0; i < 4; i++) bus_wr(32'h800 + 4 * i, 3'd2, $urandom);
        finish_frame();
        for (int i = 0; i < 4; i++) bus_rd("contention_wr", 32'h800 + 4 * i, mdl[512 + i]);

        start_frame(8, 1);
        t = 0;
        while (rx_d.size() < 2 && t < 500) begin
            @(posedge HCLK);
            t++;
        end
        check("pre_reset_words", 32'(rx_d.size() >= 2), 1);
        @(posedge HCLK); #1;
        HRESETn = 0;
        #1;
        check("reset_m_valid", 32'(m_valid), 0);
        @(posedge HCLK); #1;
        HRESETn = 1;
        len_m = 0; done_m = 0;
        check("reset_hreadyout", 32'(HREADYOUT), 1);
        check("reset_hrdata", HRDATA, 0);
        check("reset_m_last", 32'(m_last), 0);
        bus_rd("reset_status", RB + 4, 0);
        bus_rd("reset_len", RB + 8, len_m);

        start_frame(5, 2);
        finish_frame();
        d = mdl[0];
        check("led_final", 32'(LED), 32'(d[LED_W-1:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got %0d exp %0d", 0, 1);
        $fatal(1);
    end
endmodule
